// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial ripple adder. Accepts two WIDTH-bit operands and a
//             carry-in through a valid/ready handshake, adds them one bit per
//             clock (LSB first) through a single full-adder cell, and presents
//             the registered sum and carry-out through a second valid/ready
//             handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      operand width in bits (1..32)
//  Ports
//    clk        clock, all state changes on the rising edge
//    rst_n      asynchronous active-low reset
//    in_valid   operands a, b, cin are valid
//    in_ready   block can accept operands (high only while idle)
//    a, b       addends
//    cin        carry-in
//    out_valid  sum and cout are valid (high only while result is offered)
//    out_ready  consumer accepts the result
//    sum        registered sum, held until the next result is produced
//    cout       registered carry-out, held until the next result is produced
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter only ever needs to reach WIDTH-1; a 1-bit counter is kept for
  // WIDTH=1 so the vector is never zero-width.
  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_sr_shifted;

  // Single full-adder cell working on the operand LSBs and the carry flop.
  assign w_s  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign w_co = (a_sr_q[0] & b_sr_q[0]) |
                (a_sr_q[0] & carry_q)   |
                (b_sr_q[0] & carry_q);

  // New sum bit enters at the MSB; after WIDTH shifts the first bit computed
  // (the LSB) has arrived at bit 0.
  generate
    if (WIDTH == 1) begin : g_sum_sr_w1
      assign w_sum_sr_shifted = w_s;
    end else begin : g_sum_sr_wn
      assign w_sum_sr_shifted = {w_s, sum_sr_q[WIDTH-1:1]};
    end
  endgenerate

  // The oldest bit of the sum shift register is shifted out and never read;
  // the complete value is captured into sum_q on the final shift edge.
  logic w_unused;
  assign w_unused = ^sum_sr_q;

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sum_sr_d = w_sum_sr_shifted;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = w_co;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the result. The counter is held here rather
          // than incremented so it never wraps when WIDTH is a power of two.
          sum_d   = w_sum_sr_shifted;
          cout_d  = w_co;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Handshake outputs are decoded from state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
`default_nettype wire
